// File: rtl/vx_fp_round_arbiter_pkg.sv
// Shared FPU definitions: rounding-mode encodings, result flag bundle and
// the dynamic rounding-mode resolution helper.
package vx_fp_round_arbiter_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    typedef struct packed {
        logic inexact;
        logic rm_err;
    } fp_flags_t;

    // Instruction rm of DYN defers to the frm CSR; anything else is used as-is.
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
        return (rm == RM_DYN) ? frm : rm;
    endfunction

endpackage

// File: rtl/vx_fp_round_arbiter_rounding.sv
// Rounding datapath: applies one of the five RISC-V rounding modes to a
// pre-rounded magnitude with {round,sticky} bits. Reserved modes fall back
// to RNE and raise rm_err. Purely combinational.
module vx_fp_round_arbiter_rounding
    import vx_fp_round_arbiter_pkg::*;
#(
    parameter int DAT_WIDTH = 31
) (
    input  logic [DAT_WIDTH-1:0] i_value,
    input  logic                 i_sign,
    input  logic [1:0]           i_rs,
    input  logic [2:0]           i_rm,
    input  logic                 i_eff_sub,
    output logic [DAT_WIDTH-1:0] o_value,
    output logic                 o_sign,
    output logic                 o_exact_zero,
    output fp_flags_t            o_flags
);

    logic       w_round;
    logic       w_sticky;
    logic       w_rm_err;
    logic [2:0] w_mode;
    logic       w_round_up;

    assign w_round  = i_rs[1];
    assign w_sticky = i_rs[0];

    // Map reserved encodings onto RNE and flag them.
    always_comb begin
        w_rm_err = 1'b0;
        w_mode   = i_rm;
        if (i_rm > RM_RMM) begin
            w_rm_err = 1'b1;
            w_mode   = RM_RNE;
        end
    end

    // Round-up decision per mode; RNE breaks ties towards an even lsb.
    always_comb begin
        w_round_up = 1'b0;
        case (w_mode)
            RM_RNE:  w_round_up = w_round & (w_sticky | i_value[0]);
            RM_RTZ:  w_round_up = 1'b0;
            RM_RDN:  w_round_up = i_sign & (w_round | w_sticky);
            RM_RUP:  w_round_up = ~i_sign & (w_round | w_sticky);
            RM_RMM:  w_round_up = w_round;
            default: w_round_up = 1'b0;
        endcase
    end

    // Carry out of the mantissa ripples into the exponent field and is allowed
    // to wrap at the top; the producers have already saturated where needed.
    assign o_value      = i_value + DAT_WIDTH'(w_round_up);
    assign o_exact_zero = (i_value == '0) && (i_rs == 2'b00);
    // x - x produces +0 except when rounding down, which yields -0.
    assign o_sign       = (o_exact_zero && i_eff_sub) ? (w_mode == RM_RDN) : i_sign;

    assign o_flags.inexact = w_round | w_sticky;
    assign o_flags.rm_err  = w_rm_err;

endmodule

// File: rtl/vx_fp_round_arbiter.sv
// Shared FPU rounding stage: round-robin arbitration among producers, one
// rounding datapath on the granted request, and a 1-deep registered output
// with valid/ready handshake tagged by requester index and tag.
module vx_fp_round_arbiter
    import vx_fp_round_arbiter_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int DAT_WIDTH = 31,
    parameter int TAG_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    output logic [NUM_REQS-1:0]            req_ready,
    input  logic [NUM_REQS*DAT_WIDTH-1:0]  req_value,
    input  logic [NUM_REQS-1:0]            req_sign,
    input  logic [NUM_REQS*2-1:0]          req_rs,
    input  logic [NUM_REQS*3-1:0]          req_rm,
    input  logic [NUM_REQS-1:0]            req_eff_sub,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
    input  logic [2:0]                     frm,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DAT_WIDTH-1:0]           out_value,
    output logic                           out_sign,
    output logic                           out_exact_zero,
    output logic                           out_inexact,
    output logic                           out_rm_err,
    output logic [$clog2(NUM_REQS)-1:0]    out_req_idx,
    output logic [TAG_WIDTH-1:0]           out_tag
);

    localparam int IDX_W = $clog2(NUM_REQS);

    logic                 r_out_valid;
    logic [DAT_WIDTH-1:0] r_out_value;
    logic                 r_out_sign;
    logic                 r_out_exact_zero;
    logic                 r_out_inexact;
    logic                 r_out_rm_err;
    logic [IDX_W-1:0]     r_out_req_idx;
    logic [TAG_WIDTH-1:0] r_out_tag;
    logic [IDX_W-1:0]     r_ptr;

    logic                 w_accept;
    logic                 w_found;
    logic                 w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [IDX_W-1:0]     w_ptr_next;

    logic [DAT_WIDTH-1:0] w_sel_value;
    logic                 w_sel_sign;
    logic [1:0]           w_sel_rs;
    logic [2:0]           w_sel_rm;
    logic                 w_sel_eff_sub;
    logic [TAG_WIDTH-1:0] w_sel_tag;
    logic [2:0]           w_eff_rm;

    logic [DAT_WIDTH-1:0] w_rnd_value;
    logic                 w_rnd_sign;
    logic                 w_rnd_zero;
    fp_flags_t            w_rnd_flags;

    assign w_accept = ~r_out_valid | out_ready;
    assign w_grant  = w_found & w_accept & ~reset;

    // Round-robin search: first pass covers [ptr, N), second pass wraps to [0, ptr).
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!w_found && req_valid[i] && (i >= int'(r_ptr))) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'(i);
            end
        end
    end

    // One-hot ready towards the granted requester, all zero otherwise.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = w_grant && (w_grant_idx == IDX_W'(i));
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        w_sel_value   = '0;
        w_sel_sign    = 1'b0;
        w_sel_rs      = 2'b00;
        w_sel_rm      = RM_RNE;
        w_sel_eff_sub = 1'b0;
        w_sel_tag     = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_grant_idx == IDX_W'(i)) begin
                w_sel_value   = req_value[i*DAT_WIDTH +: DAT_WIDTH];
                w_sel_sign    = req_sign[i];
                w_sel_rs      = req_rs[i*2 +: 2];
                w_sel_rm      = req_rm[i*3 +: 3];
                w_sel_eff_sub = req_eff_sub[i];
                w_sel_tag     = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    assign w_eff_rm   = resolve_rm(w_sel_rm, frm);
    assign w_ptr_next = (w_grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : w_grant_idx + IDX_W'(1);

    vx_fp_round_arbiter_rounding #(
        .DAT_WIDTH (DAT_WIDTH)
    ) u_rounding (
        .i_value      (w_sel_value),
        .i_sign       (w_sel_sign),
        .i_rs         (w_sel_rs),
        .i_rm         (w_eff_rm),
        .i_eff_sub    (w_sel_eff_sub),
        .o_value      (w_rnd_value),
        .o_sign       (w_rnd_sign),
        .o_exact_zero (w_rnd_zero),
        .o_flags      (w_rnd_flags)
    );

    // Pointer moves past the winner only when a grant actually happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Output stage: load on grant, drop valid on an idle accept, hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_out_value      <= '0;
            r_out_sign       <= 1'b0;
            r_out_exact_zero <= 1'b0;
            r_out_inexact    <= 1'b0;
            r_out_rm_err     <= 1'b0;
            r_out_req_idx    <= '0;
            r_out_tag        <= '0;
        end else if (w_accept) begin
            r_out_valid <= w_grant;
            if (w_grant) begin
                r_out_value      <= w_rnd_value;
                r_out_sign       <= w_rnd_sign;
                r_out_exact_zero <= w_rnd_zero;
                r_out_inexact    <= w_rnd_flags.inexact;
                r_out_rm_err     <= w_rnd_flags.rm_err;
                r_out_req_idx    <= w_grant_idx;
                r_out_tag        <= w_sel_tag;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_value      = r_out_value;
    assign out_sign       = r_out_sign;
    assign out_exact_zero = r_out_exact_zero;
    assign out_inexact    = r_out_inexact;
    assign out_rm_err     = r_out_rm_err;
    assign out_req_idx    = r_out_req_idx;
    assign out_tag        = r_out_tag;

endmodule

// File: tb/tb_vx_fp_round_arbiter.sv
// Testbench for vx_fp_round_arbiter: directed rounding vectors, hand-written
// arbitration/backpressure/reset sequences, then randomized traffic checked
// against a behavioural model.
module tb_vx_fp_round_arbiter;

    localparam int N  = 4;
    localparam int DW = 31;
    localparam int TW = 8;
    localparam int IW = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_value;
    logic [N-1:0]      req_sign;
    logic [N*2-1:0]    req_rs;
    logic [N*3-1:0]    req_rm;
    logic [N-1:0]      req_eff_sub;
    logic [N*TW-1:0]   req_tag;
    logic [2:0]        frm;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_value;
    logic              out_sign;
    logic              out_exact_zero;
    logic              out_inexact;
    logic              out_rm_err;
    logic [IW-1:0]     out_req_idx;
    logic [TW-1:0]     out_tag;

    logic [DW-1:0] t_value   [N];
    logic          t_sign    [N];
    logic [1:0]    t_rs      [N];
    logic [2:0]    t_rm      [N];
    logic          t_eff_sub [N];
    logic [TW-1:0] t_tag     [N];

    always_comb begin
        req_value   = '0;
        req_sign    = '0;
        req_rs      = '0;
        req_rm      = '0;
        req_eff_sub = '0;
        req_tag     = '0;
        for (int i = 0; i < N; i++) begin
            req_value[i*DW +: DW] = t_value[i];
            req_sign[i]           = t_sign[i];
            req_rs[i*2 +: 2]      = t_rs[i];
            req_rm[i*3 +: 3]      = t_rm[i];
            req_eff_sub[i]        = t_eff_sub[i];
            req_tag[i*TW +: TW]   = t_tag[i];
        end
    end

    vx_fp_round_arbiter #(.NUM_REQS(N), .DAT_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_value      (req_value),
        .req_sign       (req_sign),
        .req_rs         (req_rs),
        .req_rm         (req_rm),
        .req_eff_sub    (req_eff_sub),
        .req_tag        (req_tag),
        .frm            (frm),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_value      (out_value),
        .out_sign       (out_sign),
        .out_exact_zero (out_exact_zero),
        .out_inexact    (out_inexact),
        .out_rm_err     (out_rm_err),
        .out_req_idx    (out_req_idx),
        .out_tag        (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] value;
        logic          sign;
        logic          zero;
        logic          inexact;
        logic          err;
    } res_t;

    // Reference rounding: rs viewed as the fraction below the lsb in quarters
    // (0 exact, 1 below half, 2 exactly half, 3 above half).
    function automatic res_t ref_round(input logic [DW-1:0] v, input logic s, input logic [1:0] rs,
                                       input logic [2:0] rm, input logic eff_sub, input logic [2:0] f);
        res_t r;
        int   mode;
        int   q;
        bit   up;
        bit   err;
        mode = (rm == 3'd7) ? int'(f) : int'(rm);
        err  = (mode > 4);
        if (err) mode = 0;
        q  = int'(rs);
        up = 0;
        case (mode)
            0: up = (q > 2) || (q == 2 && (v % 2 == 1));
            1: up = 0;
            2: up = s && (q != 0);
            3: up = !s && (q != 0);
            4: up = (q >= 2);
            default: up = 0;
        endcase
        r.value   = v + (up ? 1 : 0);
        r.zero    = (v == 0) && (q == 0);
        r.sign    = (r.zero && eff_sub) ? (mode == 2) : s;
        r.inexact = (q != 0);
        r.err     = err;
        return r;
    endfunction

    typedef struct packed {
        logic [DW-1:0] value;
        logic          sign;
        logic [1:0]    rs;
        logic [2:0]    rm;
        logic          eff_sub;
        logic [2:0]    frm;
        logic [DW-1:0] e_value;
        logic          e_sign;
        logic          e_zero;
        logic          e_inexact;
        logic          e_err;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic clear_reqs();
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            t_value[i] = '0; t_sign[i] = 1'b0; t_rs[i] = 2'b00;
            t_rm[i] = 3'b000; t_eff_sub[i] = 1'b0; t_tag[i] = '0;
        end
    endtask

    // Model state for the randomized phase
    logic          m_valid;
    res_t          m_res;
    logic [IW-1:0] m_idx;
    logic [TW-1:0] m_tag;
    int            m_ptr;
    logic [N-1:0]  pend;

    initial begin
        logic [N-1:0] exp_ready;
        int           g;
        bit           acc;
        bit           do_rst;
        res_t         rr;

        //          value          s  rs     rm      es frm     e_value       es ez ei ee
        vecs[0]  = '{31'h2,        0, 2'b10, 3'b000, 0, 3'b000, 31'h2,        0, 0, 1, 0};
        vecs[1]  = '{31'h3,        0, 2'b10, 3'b000, 0, 3'b000, 31'h4,        0, 0, 1, 0};
        vecs[2]  = '{31'h5,        1, 2'b01, 3'b111, 0, 3'b010, 31'h6,        1, 0, 1, 0};
        vecs[3]  = '{31'h5,        1, 2'b01, 3'b111, 0, 3'b011, 31'h5,        1, 0, 1, 0};
        vecs[4]  = '{31'h0,        0, 2'b00, 3'b010, 1, 3'b000, 31'h0,        1, 1, 0, 0};
        vecs[5]  = '{31'h3,        0, 2'b10, 3'b101, 0, 3'b000, 31'h4,        0, 0, 1, 1};
        vecs[6]  = '{31'h2,        0, 2'b10, 3'b100, 0, 3'b000, 31'h3,        0, 0, 1, 0};
        vecs[7]  = '{31'h7,        0, 2'b11, 3'b001, 0, 3'b000, 31'h7,        0, 0, 1, 0};
        vecs[8]  = '{31'h7fffffff, 0, 2'b01, 3'b011, 0, 3'b000, 31'h0,        0, 0, 1, 0};
        vecs[9]  = '{31'h0,        1, 2'b00, 3'b000, 1, 3'b000, 31'h0,        0, 1, 0, 0};
        vecs[10] = '{31'h0,        1, 2'b00, 3'b000, 0, 3'b000, 31'h0,        1, 1, 0, 0};
        vecs[11] = '{31'h1,        0, 2'b10, 3'b111, 0, 3'b110, 31'h2,        0, 0, 1, 1};
        vecs[12] = '{31'h4,        0, 2'b10, 3'b111, 0, 3'b111, 31'h4,        0, 0, 1, 1};

        reset = 1'b1; out_ready = 1'b0; frm = 3'b000;
        clear_reqs();
        req_valid = '1;
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_data", {out_value, out_sign, out_exact_zero, out_inexact, out_rm_err, out_req_idx, out_tag},
              64'(0));

        // Directed rounding vectors, rotating over requesters
        out_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            int idx;
            idx = k % N;
            @(negedge clk);
            clear_reqs();
            t_value[idx] = vecs[k].value; t_sign[idx] = vecs[k].sign; t_rs[idx] = vecs[k].rs;
            t_rm[idx] = vecs[k].rm; t_eff_sub[idx] = vecs[k].eff_sub; t_tag[idx] = TW'(8'h40 + k);
            frm = vecs[k].frm;
            req_valid[idx] = 1'b1;
            #1;
            check($sformatf("vec%0d_ready", k), 64'(req_ready), 64'(1 << idx));
            @(posedge clk);
            #1;
            req_valid = '0;
            check($sformatf("vec%0d_valid", k), 64'(out_valid), 64'(1));
            check($sformatf("vec%0d_value", k), 64'(out_value), 64'(vecs[k].e_value));
            check($sformatf("vec%0d_flags", k), 64'({out_sign, out_exact_zero, out_inexact, out_rm_err}),
                  64'({vecs[k].e_sign, vecs[k].e_zero, vecs[k].e_inexact, vecs[k].e_err}));
            check($sformatf("vec%0d_id", k), 64'({out_req_idx, out_tag}), 64'({IW'(idx), TW'(8'h40 + k)}));
        end

        // Round-robin with all requesters continuously valid
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_reqs();
        for (int i = 0; i < N; i++) t_tag[i] = TW'(i + 8'h10);
        req_valid = '1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("rr%0d_ready", c), 64'(req_ready), 64'(1 << (c % N)));
            @(posedge clk);
            #1;
            check($sformatf("rr%0d_out", c), 64'({out_valid, out_req_idx, out_tag}),
                  64'({1'b1, IW'(c % N), TW'((c % N) + 8'h10)}));
            @(negedge clk);
        end

        // Backpressure: output holds idx 1, pointer at 2
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d_ready", c), 64'(req_ready), 64'(0));
            check($sformatf("bp%0d_hold", c), 64'({out_valid, out_req_idx, out_tag}), 64'({1'b1, IW'(1), TW'(8'h11)}));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'(4));
        @(posedge clk);
        #1;
        check("bp_release_out", 64'({out_valid, out_req_idx, out_tag}), 64'({1'b1, IW'(2), TW'(8'h12)}));

        // Reset in the middle of a stall
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_stall_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_stall_valid", 64'(out_valid), 64'(0));
        check("rst_stall_first", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        check("rst_stall_out", 64'({out_valid, out_req_idx}), 64'({1'b1, IW'(0)}));

        // Randomized traffic against the model
        @(negedge clk);
        reset = 1'b1;
        clear_reqs();
        @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b0; m_res = '0; m_idx = '0; m_tag = '0; m_ptr = 0; pend = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    int sel;
                    sel = int'($urandom_range(0, 7));
                    t_value[i]   = (sel == 0) ? '0 : (sel == 1) ? '1 : DW'($urandom);
                    t_sign[i]    = 1'($urandom);
                    t_rs[i]      = (sel == 0 && $urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
                    t_rm[i]      = 3'($urandom);
                    t_eff_sub[i] = 1'($urandom);
                    t_tag[i]     = TW'($urandom);
                    pend[i]      = 1'b1;
                end
            end
            req_valid = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            frm       = 3'($urandom);
            do_rst    = ($urandom_range(0, 199) == 0);
            reset     = do_rst;
            #1;
            acc = !m_valid || out_ready;
            g   = -1;
            if (acc && !do_rst) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (g < 0 && pend[j]) g = j;
                end
            end
            exp_ready = (g >= 0) ? N'(1 << g) : '0;
            check("rnd_ready", 64'(req_ready), 64'(exp_ready));
            check("rnd_valid", 64'(out_valid), 64'(m_valid));
            check("rnd_data", {out_value, out_sign, out_exact_zero, out_inexact, out_rm_err, out_req_idx, out_tag},
                  {m_res.value, m_res.sign, m_res.zero, m_res.inexact, m_res.err, m_idx, m_tag});
            @(posedge clk);
            if (do_rst) begin
                m_valid = 1'b0; m_res = '0; m_idx = '0; m_tag = '0; m_ptr = 0;
            end else if (acc) begin
                if (g >= 0) begin
                    rr = ref_round(t_value[g], t_sign[g], t_rs[g], t_rm[g], t_eff_sub[g], frm);
                    m_res   = rr;
                    m_idx   = IW'(g);
                    m_tag   = t_tag[g];
                    m_valid = 1'b1;
                    m_ptr   = (g + 1) % N;
                    pend[g] = 1'b0;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_fp_round_arbiter.md
Name: vx_fp_round_arbiter

Overview:
Shared rounding stage for the FPU. Up to NUM_REQS producers (add, mul, fma, cvt) present pre-rounded magnitudes with round/sticky bits. A round-robin arbiter grants one request per cycle into the existing rounding datapath, resolves dynamic rounding mode from the frm CSR, and registers the result in a 1-deep valid/ready output stage tagged with requester index and tag.

Parameters:
NUM_REQS, 4, number of requesters (>=2)
DAT_WIDTH, 31, magnitude width without sign (exponent+mantissa)
TAG_WIDTH, 8, opaque per-request tag returned with result

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQS  per-requester request valid
req_ready  out  NUM_REQS  per-requester grant/accept (one-hot or zero)
req_value  in  NUM_REQS*DAT_WIDTH  absolute value, requester i at slice i
req_sign  in  NUM_REQS  sign
req_rs  in  NUM_REQS*2  {round,sticky} bits
req_rm  in  NUM_REQS*3  rounding mode; 3'b111 = DYN
req_eff_sub  in  NUM_REQS  effective subtraction flag
req_tag  in  NUM_REQS*TAG_WIDTH  tag
frm  in  3  CSR dynamic rounding mode
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_value  out  DAT_WIDTH  rounded magnitude
out_sign  out  1  result sign
out_exact_zero  out  1  exact zero
out_inexact  out  1  |rs of granted request (NX flag)
out_rm_err  out  1  effective rounding mode was invalid
out_req_idx  out  clog2(NUM_REQS)  granted requester index
out_tag  out  TAG_WIDTH  tag of granted request

Behaviour:
- Reset (sync, active-high): out_valid=0, rr pointer=0, all out_* data fields=0, req_ready=0 during reset cycle.
- accept = ~out_valid | out_ready. Arbitration only when accept=1; otherwise req_ready=0 (no grant).
- Round-robin: search req_valid from pointer upward modulo NUM_REQS; first set bit i wins; req_ready[i]=1 combinationally. Pointer <= (i+1) mod NUM_REQS on grant only; unchanged when no grant.
- Handshake per requester: transfer when req_valid[i] & req_ready[i]. Requesters must hold payload stable until granted; req_ready may depend on req_valid (no combinational loop back into req_valid permitted).
- Effective mode: rm=111 -> frm; else rm. If effective mode in {101,110,111}: round with RNE, out_rm_err=1.
- Rounding: RNE, RTZ, RDN, RUP, RMM per RISC-V; result = value + round_up, carry into exponent/overflow wraps naturally within DAT_WIDTH. Exact zero = value==0 & rs==0; exact zero with eff_sub forces sign = (mode==RDN).
- Latency: 1 cycle; granted in cycle N -> out_valid in N+1.
- Output register loads on grant; if accept=1 and no grant, out_valid<=0. If out_valid & ~out_ready, all out_* held stable (no change) until out_ready.
- Full throughput: out_valid & out_ready with pending request -> new result next cycle, no bubble.
- Single requester continuously valid gets every cycle; starvation-free: any continuously valid requester granted within NUM_REQS accepts.
- Reset mid-operation: in-flight result discarded, pointer to 0, no partial transfer.
- frm sampled in grant cycle only.

Decomposition:
- Shared FPU package: rounding mode constants (RNE, RTZ, RDN, RUP, RMM, DYN=111), result-flag struct {inexact, rm_err}.
- One sub-module: VX_fp_rounding (existing rounding datapath), instantiated once on the muxed granted request. Round-robin logic kept inline.

Test Plan:
- RNE tie: req0 value=0x2 rs=10 rm=000 -> out_value=0x2, inexact=1; value=0x3 rs=10 -> out_value=0x4.
- Round-robin: all 4 valid continuously, out_ready=1 -> out_req_idx sequence 0,1,2,3,0, one result per cycle after 1-cycle latency.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> req_ready=0, out_* unchanged; out_ready=1 -> next grant follows pointer, no loss/duplication.
- DYN mode: rm=111, frm=010, sign=1, value=0x5 rs=01 -> out_value=0x6; frm=011 same inputs -> 0x5.
- Zero/invalid: value=0 rs=00 eff_sub=1 rm=010 -> exact_zero=1, sign=1; rm=101 value=0x3 rs=10 -> 0x4, rm_err=1.
- Reset mid-stall: out_valid=1, out_ready=0, assert reset 1 cycle -> out_valid=0, next grant from requester 0 first.
